// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller:
// the forwarding-select encoding and the in-flight scoreboard entry.
package pipe_ctrl_pkg;

  localparam int SB_AW = 5;
  localparam int SB_SW = 2;

  localparam logic [SB_SW-1:0] FWD_REG = 2'b00;
  localparam logic [SB_SW-1:0] FWD_WB  = 2'b01;
  localparam logic [SB_SW-1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic             vld;
    logic             rw;
    logic             mr;
    logic [SB_AW-1:0] dest;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rw: 1'b0, mr: 1'b0, dest: {SB_AW{1'b0}}};

  // An entry is a usable producer only if it writes a register other than $0.
  function automatic logic sb_writes(input sb_entry_t e);
    return e.vld && e.rw && (e.dest != {SB_AW{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Pipeline-side bundle of the forwarding/hazard controller: ID-stage operand
// info and freeze/flush in, stall and registered EX forwarding controls out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
);
  import pipe_ctrl_pkg::*;

  logic              Hold;
  logic              Flush;
  logic [REG_AW-1:0] ID_Rs;
  logic [REG_AW-1:0] ID_Rt;
  logic              ID_UseRs;
  logic              ID_UseRt;
  logic [REG_AW-1:0] ID_Dest;
  logic              ID_RegWrite;
  logic              ID_MemRead;
  logic              Stall;
  logic              EX_Bubble;
  logic [SEL_W-1:0]  AluSrcA_Sel;
  logic [SEL_W-1:0]  AluSrcB_Sel;
  sb_entry_t         Dbg_W;

  modport master (
    output Hold, Flush, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
           ID_Dest, ID_RegWrite, ID_MemRead,
    input  Stall, EX_Bubble, AluSrcA_Sel, AluSrcB_Sel, Dbg_W
  );

  modport slave (
    input  Hold, Flush, ID_Rs, ID_Rt, ID_UseRs, ID_UseRt,
           ID_Dest, ID_RegWrite, ID_MemRead,
    output Stall, EX_Bubble, AluSrcA_Sel, AluSrcB_Sel, Dbg_W
  );

endinterface

// File: rtl/fwd_sel_cmp.sv
// Per-source forwarding select: the EX producer (newest) wins over MEM;
// an unused source or no match selects the register-file value.
module fwd_sel_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              use_i,
  input  logic [REG_AW-1:0] src_i,
  input  logic              e_wr_i,
  input  logic [REG_AW-1:0] e_dest_i,
  input  logic              m_wr_i,
  input  logic [REG_AW-1:0] m_dest_i,
  output logic [SEL_W-1:0]  sel_o
);

  // Priority compare against the EX then MEM producers.
  always_comb begin
    sel_o = FWD_REG;
    if (!use_i) begin
      sel_o = FWD_REG;
    end else if (e_wr_i && (e_dest_i == src_i)) begin
      sel_o = FWD_MEM;
    end else if (m_wr_i && (m_dest_i == src_i)) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_REG;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding and load-use hazard controller for the 5-stage pipeline.
// Optional performance counters (StallCnt, FwdCnt) under FWD_HAZARD_PERF_EN.
module fwd_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_ctrl_if.slave  bus
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FwdCnt
`endif
);

  sb_entry_t        e_q, e_d;
  sb_entry_t        m_q, m_d;
  sb_entry_t        w_q, w_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic             bubble_q, bubble_d;

  logic             stall_s;
  logic             e_wr_s;
  logic             m_wr_s;
  logic             advance_s;
  logic [SEL_W-1:0] sel_a_s;
  logic [SEL_W-1:0] sel_b_s;

  assign e_wr_s = sb_writes(e_q);
  assign m_wr_s = sb_writes(m_q);

  // A load in EX feeding the ID instruction costs one bubble; a flush overrides it.
  assign stall_s = !bus.Flush && e_wr_s && e_q.mr &&
                   ((bus.ID_UseRs && (bus.ID_Rs == e_q.dest)) ||
                    (bus.ID_UseRt && (bus.ID_Rt == e_q.dest)));

  assign advance_s = !bus.Hold && !bus.Flush && !stall_s;

  fwd_sel_cmp #(.REG_AW(REG_AW), .SEL_W(SEL_W)) u_cmp_a (
    .use_i    (bus.ID_UseRs),
    .src_i    (bus.ID_Rs),
    .e_wr_i   (e_wr_s),
    .e_dest_i (e_q.dest),
    .m_wr_i   (m_wr_s),
    .m_dest_i (m_q.dest),
    .sel_o    (sel_a_s)
  );

  fwd_sel_cmp #(.REG_AW(REG_AW), .SEL_W(SEL_W)) u_cmp_b (
    .use_i    (bus.ID_UseRt),
    .src_i    (bus.ID_Rt),
    .e_wr_i   (e_wr_s),
    .e_dest_i (e_q.dest),
    .m_wr_i   (m_wr_s),
    .m_dest_i (m_q.dest),
    .sel_o    (sel_b_s)
  );

  // Scoreboard shift and EX control next-state: hold > flush/stall > advance.
  always_comb begin
    e_d      = e_q;
    m_d      = m_q;
    w_d      = w_q;
    sel_a_d  = sel_a_q;
    sel_b_d  = sel_b_q;
    bubble_d = bubble_q;
    if (bus.Hold) begin
      e_d      = e_q;
      m_d      = m_q;
      w_d      = w_q;
      sel_a_d  = sel_a_q;
      sel_b_d  = sel_b_q;
      bubble_d = bubble_q;
    end else if (bus.Flush || stall_s) begin
      w_d      = m_q;
      m_d      = e_q;
      e_d      = SB_EMPTY;
      sel_a_d  = FWD_REG;
      sel_b_d  = FWD_REG;
      bubble_d = 1'b1;
    end else begin
      w_d      = m_q;
      m_d      = e_q;
      e_d      = '{vld: 1'b1, rw: bus.ID_RegWrite, mr: bus.ID_MemRead, dest: bus.ID_Dest};
      sel_a_d  = sel_a_s;
      sel_b_d  = sel_b_s;
      bubble_d = 1'b0;
    end
  end

  // State registers; EX starts out holding a NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= SB_EMPTY;
      m_q      <= SB_EMPTY;
      w_q      <= SB_EMPTY;
      sel_a_q  <= FWD_REG;
      sel_b_q  <= FWD_REG;
      bubble_q <= 1'b1;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      bubble_q <= bubble_d;
    end
  end

  assign bus.Stall       = stall_s;
  assign bus.EX_Bubble   = bubble_q;
  assign bus.AluSrcA_Sel = sel_a_q;
  assign bus.AluSrcB_Sel = sel_b_q;
  assign bus.Dbg_W       = w_q;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  // Counter next-state; both wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall_s && !bus.Hold) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (advance_s && ((sel_a_s != FWD_REG) || (sel_b_s != FWD_REG))) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end else begin
      fwd_cnt_d = fwd_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FwdCnt   = fwd_cnt_q;
`else
  logic unused_adv_s;
  assign unused_adv_s = advance_s;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: an instruction-level model of the
// EX/MEM producers is compared against the DUT every cycle, plus literal checks.
module tb_fwd_hazard_ctrl;

  logic clk;
  logic rst;

  fwd_hazard_ctrl_if #(.REG_AW(5), .SEL_W(2)) bus_if ();

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] fwd_cnt;
`endif

  fwd_hazard_ctrl #(.REG_AW(5), .SEL_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave)
`ifdef FWD_HAZARD_PERF_EN
    ,
    .StallCnt (stall_cnt),
    .FwdCnt   (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Instruction-level model: what each in-flight instruction writes.
  typedef struct {
    bit writes;
    int dest;
    bit is_load;
  } inst_t;

  inst_t inflight [2];   // [0] = instruction in EX, [1] = instruction in MEM
  int    exp_bubble;
  int    exp_sel_a;
  int    exp_sel_b;
  int    exp_stall_cnt;
  int    exp_fwd_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fwd_of(input bit used, input int src);
    if (!used) return 0;
    for (int age = 0; age < 2; age++) begin
      if (inflight[age].writes && inflight[age].dest != 0 && inflight[age].dest == src)
        return (age == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic int model_stall();
    int d;
    d = inflight[0].dest;
    if (bus_if.Flush) return 0;
    if (!(inflight[0].writes && inflight[0].is_load && d != 0)) return 0;
    if (bus_if.ID_UseRs && int'(bus_if.ID_Rs) == d) return 1;
    if (bus_if.ID_UseRt && int'(bus_if.ID_Rt) == d) return 1;
    return 0;
  endfunction

  // Model advance on each clock edge.
  always @(posedge clk) begin
    int st, sa, sb;
    if (rst) begin
      for (int k = 0; k < 2; k++) inflight[k] = '{writes: 1'b0, dest: 0, is_load: 1'b0};
      exp_bubble = 1; exp_sel_a = 0; exp_sel_b = 0;
      exp_stall_cnt = 0; exp_fwd_cnt = 0;
    end else if (!bus_if.Hold) begin
      st = model_stall();
      sa = fwd_of(bus_if.ID_UseRs, int'(bus_if.ID_Rs));
      sb = fwd_of(bus_if.ID_UseRt, int'(bus_if.ID_Rt));
      if (st != 0) exp_stall_cnt++;
      inflight[1] = inflight[0];
      if (bus_if.Flush || st != 0) begin
        inflight[0] = '{writes: 1'b0, dest: 0, is_load: 1'b0};
        exp_bubble = 1; exp_sel_a = 0; exp_sel_b = 0;
      end else begin
        inflight[0] = '{writes: bus_if.ID_RegWrite, dest: int'(bus_if.ID_Dest),
                        is_load: bus_if.ID_MemRead};
        exp_bubble = 0; exp_sel_a = sa; exp_sel_b = sb;
        if (sa != 0 || sb != 0) exp_fwd_cnt++;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall",  int'(bus_if.Stall),       model_stall());
      chk("cyc_bubble", int'(bus_if.EX_Bubble),   exp_bubble);
      chk("cyc_sel_a",  int'(bus_if.AluSrcA_Sel), exp_sel_a);
      chk("cyc_sel_b",  int'(bus_if.AluSrcB_Sel), exp_sel_b);
`ifdef FWD_HAZARD_PERF_EN
      chk("cyc_stall_cnt", int'(stall_cnt), exp_stall_cnt);
      chk("cyc_fwd_cnt",   int'(fwd_cnt),   exp_fwd_cnt);
`endif
    end
  end

  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit rw, input bit mr);
    bus_if.ID_Rs       = 5'(rs);
    bus_if.ID_Rt       = 5'(rt);
    bus_if.ID_UseRs    = urs;
    bus_if.ID_UseRt    = urt;
    bus_if.ID_Dest     = 5'(dest);
    bus_if.ID_RegWrite = rw;
    bus_if.ID_MemRead  = mr;
  endtask

  task automatic nop();
    issue(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef FWD_HAZARD_PERF_EN
    int held_cnt;
`endif
    rst = 1'b1;
    bus_if.Hold = 1'b0;
    bus_if.Flush = 1'b0;
    nop();
    step();
    chk_en = 1'b1;
    step();
    chk("rst_bubble", int'(bus_if.EX_Bubble),   1);
    chk("rst_sel_a",  int'(bus_if.AluSrcA_Sel), 0);
    chk("rst_sel_b",  int'(bus_if.AluSrcB_Sel), 0);
    chk("rst_stall",  int'(bus_if.Stall),       0);
    rst = 1'b0;

    // add $3,$1,$2 ; sub $4,$3,$5
    issue(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); step();
    issue(3, 5, 1'b1, 1'b1, 4, 1'b1, 1'b0); #1;
    chk("exmem_nostall", int'(bus_if.Stall), 0);
    step();
    chk("exmem_sel_a",  int'(bus_if.AluSrcA_Sel), 2);
    chk("exmem_sel_b",  int'(bus_if.AluSrcB_Sel), 0);
    chk("exmem_bubble", int'(bus_if.EX_Bubble),   0);

    // add $3 ; nop ; or $6,$7,$3
    issue(1, 2, 1'b1, 1'b1, 3, 1'b1, 1'b0); step();
    nop(); step();
    issue(7, 3, 1'b1, 1'b1, 6, 1'b1, 1'b0); step();
    chk("wb_sel_a", int'(bus_if.AluSrcA_Sel), 0);
    chk("wb_sel_b", int'(bus_if.AluSrcB_Sel), 1);

    // lw $8,0($9) ; add $10,$8,$8
    issue(9, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1); step();
    issue(8, 8, 1'b1, 1'b1, 10, 1'b1, 1'b0); #1;
    chk("lu_stall", int'(bus_if.Stall), 1);
    step();
    chk("lu_bubble",  int'(bus_if.EX_Bubble), 1);
    chk("lu_stall_1", int'(bus_if.Stall),     0);
    step();
    chk("lu_sel_a",    int'(bus_if.AluSrcA_Sel), 1);
    chk("lu_sel_b",    int'(bus_if.AluSrcB_Sel), 1);
    chk("lu_bubble_0", int'(bus_if.EX_Bubble),   0);

    // add $0,$1,$2 ; add $4,$0,$0
    issue(1, 2, 1'b1, 1'b1, 0, 1'b1, 1'b0); step();
    issue(0, 0, 1'b1, 1'b1, 4, 1'b1, 1'b0); #1;
    chk("r0_stall", int'(bus_if.Stall), 0);
    step();
    chk("r0_sel_a", int'(bus_if.AluSrcA_Sel), 0);
    chk("r0_sel_b", int'(bus_if.AluSrcB_Sel), 0);

    // lw $8 ; dependent add under Hold for 3 cycles
    issue(9, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1); step();
    issue(8, 8, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    bus_if.Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_stall",  int'(bus_if.Stall),     1);
      chk("hold_bubble", int'(bus_if.EX_Bubble), 0);
    end
    bus_if.Hold = 1'b0;
    step();
    chk("hold_rel_bubble", int'(bus_if.EX_Bubble), 1);
    chk("hold_rel_stall",  int'(bus_if.Stall),     0);
    step();
    chk("hold_sel_a", int'(bus_if.AluSrcA_Sel), 1);
    chk("hold_sel_b", int'(bus_if.AluSrcB_Sel), 1);

    // Flush coinciding with a load-use hazard
    issue(9, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1); step();
    issue(8, 8, 1'b1, 1'b1, 10, 1'b1, 1'b0);
    bus_if.Flush = 1'b1; #1;
    chk("flush_stall", int'(bus_if.Stall), 0);
`ifdef FWD_HAZARD_PERF_EN
    held_cnt = int'(stall_cnt);
`endif
    step();
    bus_if.Flush = 1'b0;
    nop();
    chk("flush_bubble", int'(bus_if.EX_Bubble),   1);
    chk("flush_sel_a",  int'(bus_if.AluSrcA_Sel), 0);
    chk("flush_sel_b",  int'(bus_if.AluSrcB_Sel), 0);
`ifdef FWD_HAZARD_PERF_EN
    chk("flush_stall_cnt", int'(stall_cnt), held_cnt);
`endif

    // EX on Rs and MEM on Rt at once
    issue(1, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0); step();
    issue(1, 2, 1'b1, 1'b1, 6, 1'b1, 1'b0); step();
    issue(6, 5, 1'b1, 1'b1, 7, 1'b1, 1'b0); step();
    chk("mix_sel_a", int'(bus_if.AluSrcA_Sel), 2);
    chk("mix_sel_b", int'(bus_if.AluSrcB_Sel), 1);

    // Unused sources never forward
    issue(7, 7, 1'b0, 1'b0, 9, 1'b1, 1'b0); step();
    chk("unused_sel_a", int'(bus_if.AluSrcA_Sel), 0);
    chk("unused_sel_b", int'(bus_if.AluSrcB_Sel), 0);

    // Non-writing producer of $3 then reader of $3
    issue(1, 2, 1'b1, 1'b1, 3, 1'b0, 1'b0); step();
    issue(3, 3, 1'b1, 1'b1, 11, 1'b1, 1'b0); step();
    chk("norw_sel_a", int'(bus_if.AluSrcA_Sel), 0);

    // Back-to-back loads to $8, then a consumer
    issue(9, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1); step();
    issue(9, 0, 1'b1, 1'b0, 8, 1'b1, 1'b1); step();
    issue(8, 2, 1'b1, 1'b1, 12, 1'b1, 1'b0); #1;
    chk("ll_stall", int'(bus_if.Stall), 1);
    step(); step();
    chk("ll_sel_a", int'(bus_if.AluSrcA_Sel), 1);
    nop(); step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
